// File: rtl/rv32i_dmem_responder.sv
// Data-memory responder for the MEM stage: word-organised RAM with byte/half/word
// access, programmable wait states, stall back-pressure and misalignment flagging.
module rv32i_dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        mem_re_i,
  input  logic        mem_we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ready_o,
  output logic        stall_o,
  output logic        misalign_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [2:0] CNT_INIT = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  logic [1:0]    state;
  logic [2:0]    cnt;
  logic [AW+1:0] lat_addr;
  logic [31:0]   lat_wdata;
  logic [2:0]    lat_f3;
  logic          lat_we;
  logic          mis_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          req, is_idle, commit, acc_we, acc_mis, is_byte, is_half;
  logic [AW+1:0] acc_addr;
  logic [31:0]   acc_wdata, lane_data, shifted, load_val;
  logic [2:0]    acc_f3;
  logic [AW-1:0] acc_idx;
  logic [3:0]    be;
  logic          unused_addr_hi;

  assign unused_addr_hi = ^addr_i[31:AW+2];

  // With zero wait states the commit edge coincides with capture, so the access
  // fields come straight from the inputs in IDLE and from the latches otherwise.
  always_comb begin
    req       = mem_re_i | mem_we_i;
    is_idle   = (state == S_IDLE);
    acc_we    = is_idle ? mem_we_i : lat_we;
    acc_addr  = is_idle ? addr_i[AW+1:0] : lat_addr;
    acc_wdata = is_idle ? wdata_i : lat_wdata;
    acc_f3    = is_idle ? funct3_i : lat_f3;
    acc_idx   = acc_addr[AW+1:2];
    is_byte   = (acc_f3[1:0] == 2'b00);
    is_half   = (acc_f3[1:0] == 2'b01);
    acc_mis   = (is_half & acc_addr[0]) | (~is_byte & ~is_half & (|acc_addr[1:0]));
    commit    = resetn_i & ((is_idle & req & (WAIT_STATES == 0)) |
                            ((state == S_WAIT) & (cnt == 3'd0)));
    if (is_byte) begin
      be        = 4'b0001 << acc_addr[1:0];
      lane_data = {4{acc_wdata[7:0]}};
    end else if (is_half) begin
      be        = acc_addr[1] ? 4'b1100 : 4'b0011;
      lane_data = {2{acc_wdata[15:0]}};
    end else begin
      be        = 4'b1111;
      lane_data = acc_wdata;
    end
    shifted = mem[acc_idx] >> {acc_addr[1:0], 3'b000};
    if (is_byte)
      load_val = acc_f3[2] ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
    else if (is_half)
      load_val = acc_f3[2] ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
    else
      load_val = shifted;
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_f3    <= '0;
      lat_we    <= 1'b0;
      mis_q     <= 1'b0;
      rdata_o   <= '0;
    end else begin
      case (state)
        S_IDLE: if (req) begin
          lat_addr  <= addr_i[AW+1:0];
          lat_wdata <= wdata_i;
          lat_f3    <= funct3_i;
          lat_we    <= mem_we_i;
          cnt       <= CNT_INIT;
          state     <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
        end
        S_WAIT: begin
          if (cnt == 3'd0) state <= S_RESP;
          else             cnt   <= cnt - 3'd1;
        end
        default: state <= S_IDLE;
      endcase
      if (commit) begin
        mis_q <= acc_mis;
        if (!acc_we) rdata_o <= acc_mis ? '0 : load_val;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (commit && acc_we && !acc_mis) begin
      for (int unsigned i = 0; i < 4; i++)
        if (be[i]) mem[acc_idx][8*i +: 8] <= lane_data[8*i +: 8];
    end
  end

  assign stall_o    = resetn_i & ((is_idle & req) | (state == S_WAIT));
  assign ready_o    = (state == S_RESP);
  assign misalign_o = ready_o & mis_q;

endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// Directed bench for rv32i_dmem_responder: one instance with two wait states,
// one with none; expected values are hand-computed constants.
module tb_rv32i_dmem_responder;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        re2 = 1'b0, we2 = 1'b0, re0 = 1'b0, we0 = 1'b0;
  logic [2:0]  f32 = '0, f30 = '0;
  logic [31:0] addr2 = '0, addr0 = '0, wd2 = '0, wd0 = '0;
  logic [31:0] rd2, rd0;
  logic        rdy2, rdy0, stl2, stl0, mis2, mis0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv32i_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) u_dut2 (
    .clk_i(clk), .resetn_i(resetn), .mem_re_i(re2), .mem_we_i(we2),
    .funct3_i(f32), .addr_i(addr2), .wdata_i(wd2), .rdata_o(rd2),
    .ready_o(rdy2), .stall_o(stl2), .misalign_o(mis2));

  rv32i_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut0 (
    .clk_i(clk), .resetn_i(resetn), .mem_re_i(re0), .mem_we_i(we0),
    .funct3_i(f30), .addr_i(addr0), .wdata_i(wd0), .rdata_o(rd0),
    .ready_o(rdy0), .stall_o(stl0), .misalign_o(mis0));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One access on the selected instance; request dropped after the capture cycle.
  // lat = cycle index of the ready pulse (-1 on timeout), nstall = stalled cycles seen.
  task automatic access(input int sel, input logic re, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic mis, output int lat, output int nstall);
    lat = -1; nstall = 0; rd = '0; mis = 1'b0;
    @(posedge clk); #1;
    if (sel == 2) begin re2 = re; we2 = we; f32 = f3; addr2 = a; wd2 = wd; end
    else          begin re0 = re; we0 = we; f30 = f3; addr0 = a; wd0 = wd; end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if ((sel == 2) ? stl2 : stl0) nstall++;
      if ((sel == 2) ? rdy2 : rdy0) begin
        lat = c;
        rd  = (sel == 2) ? rd2 : rd0;
        mis = (sel == 2) ? mis2 : mis0;
        break;
      end
      @(posedge clk); #1;
      re2 = 1'b0; we2 = 1'b0; re0 = 1'b0; we0 = 1'b0;
    end
  endtask

  logic [31:0] rd;
  logic        mis;
  int          lat, nst, pulses;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdata", rd2, 32'h0);
    check("reset_ready", {31'd0, rdy2}, 32'h0);
    check("reset_stall", {31'd0, stl2}, 32'h0);
    check("reset_misalign", {31'd0, mis2}, 32'h0);
    @(negedge clk); resetn = 1'b1;

    // Word store then load, latency and stall length
    access(2, 1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd, mis, lat, nst);
    check("sw_latency", lat, 3);
    check("sw_stall_cycles", nst, 3);
    check("sw_misalign", {31'd0, mis}, 32'h0);
    access(2, 1'b1, 1'b0, 3'd2, 32'h10, 32'h0, rd, mis, lat, nst);
    check("lw_10", rd, 32'hDEADBEEF);
    check("lw_latency", lat, 3);

    // Byte store with signed/unsigned byte loads
    access(2, 1'b0, 1'b1, 3'd0, 32'h11, 32'h00000080, rd, mis, lat, nst);
    access(2, 1'b1, 1'b0, 3'd0, 32'h11, 32'h0, rd, mis, lat, nst);
    check("lb_11", rd, 32'hFFFFFF80);
    access(2, 1'b1, 1'b0, 3'd4, 32'h11, 32'h0, rd, mis, lat, nst);
    check("lbu_11", rd, 32'h00000080);
    access(2, 1'b1, 1'b0, 3'd2, 32'h10, 32'h0, rd, mis, lat, nst);
    check("lw_after_sb", rd, 32'hDEAD80EF);
    access(2, 1'b1, 1'b0, 3'd1, 32'h12, 32'h0, rd, mis, lat, nst);
    check("lh_12", rd, 32'hFFFFDEAD);
    access(2, 1'b1, 1'b0, 3'd5, 32'h10, 32'h0, rd, mis, lat, nst);
    check("lhu_10", rd, 32'h000080EF);

    // Misaligned accesses
    access(2, 1'b1, 1'b0, 3'd2, 32'h12, 32'h0, rd, mis, lat, nst);
    check("lw_mis_flag", {31'd0, mis}, 32'h1);
    check("lw_mis_rdata", rd, 32'h0);
    check("lw_mis_latency", lat, 3);
    access(2, 1'b0, 1'b1, 3'd1, 32'h13, 32'h0000FFFF, rd, mis, lat, nst);
    check("sh_mis_flag", {31'd0, mis}, 32'h1);
    access(2, 1'b1, 1'b0, 3'd2, 32'h10, 32'h0, rd, mis, lat, nst);
    check("word_10_unchanged", rd, 32'hDEAD80EF);
    check("aligned_misalign_low", {31'd0, mis}, 32'h0);

    // Back-to-back loads with mem_re held high
    access(2, 1'b0, 1'b1, 3'd2, 32'h14, 32'h01020304, rd, mis, lat, nst);
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      re2 = (c <= 4); f32 = 3'd2; addr2 = (c < 4) ? 32'h10 : 32'h14;
      @(negedge clk);
      if (rdy2) pulses++;
      if (c == 3) begin
        check("b2b_ready_c3", {31'd0, rdy2}, 32'h1);
        check("b2b_rdata_1", rd2, 32'hDEAD80EF);
      end
      if (c == 4) check("b2b_stall_c4", {31'd0, stl2}, 32'h1);
      if (c == 7) begin
        check("b2b_ready_c7", {31'd0, rdy2}, 32'h1);
        check("b2b_rdata_2", rd2, 32'h01020304);
      end
    end
    check("b2b_pulses", pulses, 2);

    // Reset during a pending store
    access(2, 1'b0, 1'b1, 3'd2, 32'h20, 32'h12345678, rd, mis, lat, nst);
    @(posedge clk); #1;
    we2 = 1'b1; f32 = 3'd2; addr2 = 32'h20; wd2 = 32'hAAAAAAAA;
    @(posedge clk); #1;
    we2 = 1'b0;
    #2 resetn = 1'b0;
    #1;
    check("rst_mid_stall", {31'd0, stl2}, 32'h0);
    check("rst_mid_ready", {31'd0, rdy2}, 32'h0);
    check("rst_mid_rdata", rd2, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk); resetn = 1'b1;
    access(2, 1'b1, 1'b0, 3'd2, 32'h20, 32'h0, rd, mis, lat, nst);
    check("store_dropped", rd, 32'h12345678);

    // Zero wait states, simultaneous re/we, address wrap
    access(0, 1'b1, 1'b1, 3'd2, 32'h30, 32'h5, rd, mis, lat, nst);
    check("ws0_stall_cycles", nst, 1);
    check("ws0_latency", lat, 1);
    access(0, 1'b1, 1'b0, 3'd2, 32'h30, 32'h0, rd, mis, lat, nst);
    check("ws0_lw_30", rd, 32'h00000005);
    access(0, 1'b1, 1'b0, 3'd2, 32'h1030, 32'h0, rd, mis, lat, nst);
    check("ws0_wrap_1030", rd, 32'h00000005);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
